// File: rtl/palu_pkg.sv
// Shared types and the width-agnostic ALU datapath for palu_pipe.
// The compute function works on PALU_MAX_W bits and masks down to the caller's width.
package palu_pkg;

  localparam int PALU_MAX_W = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } palu_op_t;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } palu_flags_t;

  typedef struct packed {
    palu_flags_t             f;
    logic [PALU_MAX_W-1:0]   r;
  } palu_res_t;

  // w is the live operand width (power of two, 4..PALU_MAX_W); bits above w are ignored.
  function automatic palu_res_t palu_compute(input logic [PALU_MAX_W-1:0] a_in,
                                             input logic [PALU_MAX_W-1:0] b_in,
                                             input palu_op_t op, input int w);
    logic [PALU_MAX_W-1:0] msk, a, b, as, bs, r;
    logic signed [PALU_MAX_W-1:0] sra_t;
    logic [PALU_MAX_W:0] sum;
    int sh;
    logic c, v;
    palu_res_t res;
    msk   = (w >= PALU_MAX_W) ? '1 : ((PALU_MAX_W'(1) << w) - PALU_MAX_W'(1));
    a     = a_in & msk;
    b     = b_in & msk;
    as    = a[w-1] ? (a | ~msk) : a;
    bs    = b[w-1] ? (b | ~msk) : b;
    sh    = 32'(b[$clog2(PALU_MAX_W)-1:0]) & (w - 1);
    sum   = '0;
    sra_t = '0;
    r     = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[PALU_MAX_W-1:0] & msk;
        c   = sum[w];
        v   = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      OP_SUB: begin
        // a + ~b + 1: carry out of bit w is the "no borrow" indication
        sum = {1'b0, a} + {1'b0, ~b & msk} + {{PALU_MAX_W{1'b0}}, 1'b1};
        r   = sum[PALU_MAX_W-1:0] & msk;
        c   = sum[w];
        v   = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = (a << sh) & msk;
      OP_SRL:  r = a >> sh;
      OP_SRA: begin
        sra_t = $signed(as) >>> sh;
        r     = sra_t & msk;
      end
      OP_SLT:  r[0] = $signed(as) < $signed(bs);
      OP_SLTU: r[0] = a < b;
      default: r = '0;
    endcase
    res.r = r;
    res.f = '{z: (r == '0), c: c, v: v};
    return res;
  endfunction

endpackage

// File: rtl/palu_slice.sv
// One elastic register slice: loads whenever it is empty or its content moves on.
module palu_slice #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid_i,
  input  logic [PW-1:0] up_data_i,
  output logic          up_ready_o,
  output logic          dn_valid_o,
  output logic [PW-1:0] dn_data_o,
  input  logic          dn_ready_i
);

  logic          vld_q, vld_d;
  logic [PW-1:0] data_q, data_d;

  assign up_ready_o = !vld_q || dn_ready_i;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (up_ready_o) begin
      vld_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign dn_valid_o = vld_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/palu_pipe.sv
// Pipelined ALU: combinational compute on the accepted beat, then STAGES elastic slices.
// WIDTH must not exceed palu_pkg::PALU_MAX_W.
module palu_pipe
  import palu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  palu_op_t         op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output palu_flags_t      flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = TAG_W + 3 + WIDTH;

  logic                     rdy_en_q;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][PW-1:0]  data_pipe;
  palu_res_t                res;
  logic                     unused_hi;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  assign res          = palu_compute(PALU_MAX_W'(a), PALU_MAX_W'(b), op, WIDTH);
  assign vld_pipe[0]  = in_valid && rdy_en_q;
  assign data_pipe[0] = {in_tag, res.f, res.r[WIDTH-1:0]};

  if (WIDTH < PALU_MAX_W) begin : g_hi
    assign unused_hi = ^res.r[PALU_MAX_W-1:WIDTH];
  end else begin : g_nohi
    assign unused_hi = 1'b0;
  end

  // Ready travels back per stage in separate nets so the chain never loops through one vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic up_rdy, dn_rdy;
    if (k == STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stg[k+1].up_rdy;
    end
    palu_slice #(.PW(PW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .up_valid_i(vld_pipe[k]),
      .up_data_i (data_pipe[k]),
      .up_ready_o(up_rdy),
      .dn_valid_o(vld_pipe[k+1]),
      .dn_data_o (data_pipe[k+1]),
      .dn_ready_i(dn_rdy)
    );
  end

  assign in_ready                = rdy_en_q && g_stg[0].up_rdy;
  assign out_valid               = vld_pipe[STAGES];
  assign {out_tag, flags, r}     = data_pipe[STAGES];

endmodule

// File: tb/tb_palu_pipe.sv
// Scoreboard bench for palu_pipe at WIDTH=8, STAGES=3: directed vectors, backpressure, random, flush.
module tb_palu_pipe;
  import palu_pkg::*;

  localparam int W = 8, ST = 3, TW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0]  a = '0, b = '0, r;
  palu_op_t      op = OP_ADD;
  logic [TW-1:0] in_tag = '0, out_tag;
  palu_flags_t   flags;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [2:0]    f;
    logic [W-1:0]  r;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, pop_cnt = 0, last_pop = 0;
  int c0, p0;

  palu_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .flags(flags), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input palu_op_t o, input logic [3:0] t);
    exp_t e;
    logic [8:0] s;
    logic [2:0] sh;
    logic c, v;
    sh = y[2:0]; c = 1'b0; v = 1'b0; s = '0;
    e.tag = t; e.r = '0;
    case (o)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[7:0]; c = s[8];
        v = (x[7] == y[7]) && (e.r[7] != x[7]);
      end
      OP_SUB: begin
        e.r = x - y; c = (x >= y);
        v = (x[7] != y[7]) && (e.r[7] != x[7]);
      end
      OP_AND:  e.r = x & y;
      OP_OR:   e.r = x | y;
      OP_XOR:  e.r = x ^ y;
      OP_SLL:  e.r = x << sh;
      OP_SRL:  e.r = x >> sh;
      OP_SRA:  e.r = 8'($signed(x) >>> sh);
      OP_SLT:  e.r = {7'd0, $signed(x) < $signed(y)};
      OP_SLTU: e.r = {7'd0, x < y};
      default: e.r = '0;
    endcase
    e.f = {e.r == 8'd0, c, v};
    return e;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input palu_op_t o,
                      input logic [3:0] t, input bit use_exp,
                      input logic [7:0] er, input logic [2:0] ef);
    int n = 0;
    a = x; b = y; op = o; in_tag = t; in_valid = 1'b1;
    #2;
    while (!in_ready && n < 50) begin
      @(negedge clk); #2; n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (use_exp) sb.push_back(exp_t'{t, ef, er});
    else         sb.push_back(model(x, y, o, t));
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_tag), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("r",     32'(r),       32'(e.r));
        chk("flags", 32'(flags),   32'(e.f));
        chk("tag",   32'(out_tag), 32'(e.tag));
      end
      pop_cnt++;
      last_pop = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_r",         32'(r),         0);
    chk("rst_flags",     32'(flags),     0);
    chk("rst_tag",       32'(out_tag),   0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("rdy_after_rst", 32'(in_ready), 1);
    @(negedge clk);

    // latency: ADD carry-out wraps to zero
    send(8'hFF, 8'h01, OP_ADD, 4'h5, 1, 8'h00, 3'b110);
    in_valid = 1'b0;
    #1 chk("lat_c1", 32'(out_valid), 0);
    @(negedge clk); #1 chk("lat_c2", 32'(out_valid), 0);
    @(negedge clk); #1 chk("lat_c3", 32'(out_valid), 1);
    @(negedge clk);

    send(8'h80, 8'h01, OP_SUB, 4'h1, 1, 8'h7F, 3'b011);
    send(8'h01, 8'h02, OP_SUB, 4'h2, 1, 8'hFF, 3'b000);
    send(8'h90, 8'h0A, OP_SRA, 4'h3, 1, 8'hE4, 3'b000);
    send(8'hFF, 8'h01, OP_SLT, 4'h4, 1, 8'h01, 3'b000);
    send(8'hFF, 8'h01, OP_SLTU, 4'h5, 1, 8'h00, 3'b100);
    send(8'h12, 8'h34, palu_op_t'(4'hF), 4'h6, 1, 8'h00, 3'b100);
    send(8'h7F, 8'h01, OP_ADD, 4'h7, 1, 8'h80, 3'b001);
    send(8'h81, 8'h0F, OP_SLL, 4'h8, 1, 8'h80, 3'b000);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // backpressure: three slices fill, fourth beat stalls
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i), 8'h01, OP_ADD, 4'(i), 0, 8'h0, 3'b0);
    a = 8'h03; b = 8'h01; op = OP_ADD; in_tag = 4'h3; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("bp_full_rdy", 32'(in_ready),  0);
      chk("bp_hold_vld", 32'(out_valid), 1);
      chk("bp_hold_tag", 32'(out_tag),   0);
      chk("bp_hold_r",   32'(r),         1);
      @(negedge clk);
    end
    c0 = cyc; p0 = pop_cnt;
    out_ready = 1'b1;
    send(8'h03, 8'h01, OP_ADD, 4'h3, 0, 8'h0, 3'b0);
    send(8'h04, 8'h01, OP_ADD, 4'h4, 0, 8'h0, 3'b0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_cnt",  32'(pop_cnt - p0),  5);
    chk("bp_span", 32'(last_pop - c0), 4);

    // random back-to-back at full throughput
    c0 = cyc; p0 = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      chk("rnd_rdy", 32'(in_ready), 1);
      send(8'($urandom), 8'($urandom), palu_op_t'($urandom_range(0, 9)), 4'(i), 0, 8'h0, 3'b0);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rnd_cnt",  32'(pop_cnt - p0),  20);
    chk("rnd_span", 32'(last_pop - c0), 22);

    // reset flush with two beats in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, OP_ADD, 4'hA, 0, 8'h0, 3'b0);
    send(8'h33, 8'h44, OP_XOR, 4'hB, 0, 8'h0, 3'b0);
    in_valid = 1'b0;
    #1 chk("fl_pre_vld", 32'(out_valid), 0);
    @(negedge clk); #1 chk("fl_vld", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("fl_async", 32'(out_valid), 0);
    sb.delete();
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    send(8'h05, 8'h03, OP_SUB, 4'hC, 1, 8'h02, 3'b010);
    in_valid = 1'b0;
    #1 chk("fl_lat1", 32'(out_valid), 0);
    @(negedge clk); #1 chk("fl_lat2", 32'(out_valid), 0);
    @(negedge clk); #1 chk("fl_lat3", 32'(out_valid), 1);
    repeat (6) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
